// File: rtl/riscv_demux_reg.sv
// Registered 1-to-N demultiplexer: steers a valid/ready word stream into one-deep
// per-port output slots, packed as concatenated lanes (lane i at XLEN*i).
module riscv_demux_reg #(
  parameter int N_DEMUX_OUT = 2,
  parameter int XLEN        = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_demux_valid,
  output logic                          o_demux_ready,
  input  logic [XLEN-1:0]               i_demux_data,
  input  logic [$clog2(N_DEMUX_OUT)-1:0] i_demux_sel,
  output logic [N_DEMUX_OUT-1:0]        o_demux_concat_valid,
  input  logic [N_DEMUX_OUT-1:0]        i_demux_concat_ready,
  output logic [N_DEMUX_OUT*XLEN-1:0]   o_demux_concat_data,
  output logic                          o_demux_err,
  output logic [7:0]                    o_demux_drop_cnt
);

  localparam int SEL_W = $clog2(N_DEMUX_OUT);
  localparam logic [SEL_W:0] N_SEL = (SEL_W+1)'(N_DEMUX_OUT);

  logic [N_DEMUX_OUT-1:0]      valid_q, valid_d;
  logic [N_DEMUX_OUT*XLEN-1:0] data_q, data_d;
  logic                        err_q, err_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;

  logic                   sel_oob;
  logic                   slot_ready;
  logic                   accept;
  logic [N_DEMUX_OUT-1:0] wr_en;

  // A full slot still accepts when its consumer drains it in the same cycle.
  always_comb begin
    sel_oob    = ({1'b0, i_demux_sel} >= N_SEL);
    slot_ready = 1'b0;
    wr_en      = '0;
    for (int i = 0; i < N_DEMUX_OUT; i++) begin
      if (i_demux_sel == SEL_W'(i)) begin
        slot_ready = ~valid_q[i] | i_demux_concat_ready[i];
      end
    end
    o_demux_ready = i_rstn & (sel_oob | slot_ready);
    accept        = i_demux_valid & o_demux_ready;
    for (int i = 0; i < N_DEMUX_OUT; i++) begin
      wr_en[i] = accept & (i_demux_sel == SEL_W'(i));
    end
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    err_d      = accept & sel_oob;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < N_DEMUX_OUT; i++) begin
      valid_d[i] = wr_en[i] | (valid_q[i] & ~i_demux_concat_ready[i]);
      if (wr_en[i]) begin
        data_d[i*XLEN +: XLEN] = i_demux_data;
      end
    end
    if (err_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_demux_concat_valid = valid_q;
  assign o_demux_concat_data  = data_q;
  assign o_demux_err          = err_q;
  assign o_demux_drop_cnt     = drop_cnt_q;

endmodule

// File: doc/riscv_demux_reg.md
# riscv_demux_reg

Registered 1-to-N demultiplexer: the write-side counterpart of the core's N-to-1 data mux. A single XLEN-wide valid/ready stream carries a destination select. Each accepted word is steered into a one-deep output register for the selected port, and held there until that port's consumer accepts it. Output data is packed into one concatenated bus in the same lane order the mux consumes (lane i at bits XLEN*(i+1)-1 down to XLEN*i). It sits between a producer, such as a load/store response or write-back source, and N independent consumers.

## Interface
- N_DEMUX_OUT, 2, number of output ports. Legal range 2..16.
- i_clk, in, 1, clock. All state updates on the rising edge.
- i_rstn, in, 1, asynchronous active-low reset.
- i_demux_valid, in, 1, input word valid.
- o_demux_ready, out, 1, input can be accepted this cycle.
- i_demux_data, in, XLEN, input word.
- i_demux_sel, in, $clog2(N_DEMUX_OUT), destination port index.
- o_demux_concat_valid, out, N_DEMUX_OUT, per-port valid. Bit i belongs to port i.
- i_demux_concat_ready, in, N_DEMUX_OUT, per-port consumer ready.
- o_demux_concat_data, out, N_DEMUX_OUT*XLEN, per-port registered data in concatenated lanes.
- o_demux_err, out, 1, one-cycle pulse when a word with an out-of-range select is accepted.
- o_demux_drop_cnt, out, 8, saturating count of out-of-range words accepted.

## Operation
- **Per-port slot state:** each port has one slot (valid bit plus XLEN data register).
  - EMPTY -> FULL on accept with sel==i.
  - FULL -> EMPTY on valid_i & ready_i with no new write to port i.
  - FULL -> FULL (data replaced) on drain plus write in the same cycle.
- **Accept:** i_demux_valid & o_demux_ready.
- **o_demux_ready:**
  - sel < N: 1 when slot[sel] is EMPTY, or FULL and i_demux_concat_ready[sel]==1 (pass-through drain).
  - sel >= N (possible only when N is not a power of 2): always 1.
  - 0 whenever i_rstn==0.
- **ready/valid dependency:** o_demux_ready depends combinationally on i_demux_sel and i_demux_concat_ready. It does not depend on i_demux_valid.
- **Out-of-range select:** the word is accepted and discarded, no slot changes, o_demux_err pulses high on the next cycle, and o_demux_drop_cnt increments, saturating at 255.
- **Independent ports:** a stalled port never blocks an input targeting a different port.
- **Data stability:** a slot's data and valid hold stable while FULL and not drained. Data of an EMPTY slot keeps its last value and is don't-care.
- **Input-side rule:** once i_demux_valid is raised, data and sel must be held until accepted. The block does not check this.

## Timing
- **Reset values (asynchronous, immediate on i_rstn low):** all o_demux_concat_valid=0, all data lanes=0, o_demux_err=0, o_demux_drop_cnt=0, o_demux_ready=0.
- **Latency:** a word accepted at edge k appears on its port with valid=1 in the cycle after edge k (1 cycle).
- **Throughput:** 1 word/cycle sustained to any single port while its ready is held high. Alternating ports also sustain 1/cycle.
- **Backpressure:** slot FULL and port ready=0 -> o_demux_ready=0 for that sel, and the slot is unchanged.
- **Simultaneous drain and write, same port:** the new word replaces the old one. Valid stays 1, with no bubble.
- **Reset mid-operation:** all in-flight slot contents are lost. After release, o_demux_ready rises in the first cycle with i_rstn=1.
- **o_demux_err timing:** registered. High for exactly one cycle per discarded word, back-to-back if consecutive.

## Test plan
- **Reset:** assert i_rstn=0 mid-burst with port 1 FULL -> all valids 0, lanes 0, o_demux_ready 0, drop_cnt 0 immediately (no clock edge needed).
- **Basic steer (N=4):** send 0xDEADBEEF sel=2 with all ports ready -> next cycle valid=4'b0100, lane 2=0xDEADBEEF, other valids 0. Slot drains the following cycle.
- **Backpressure and pass-through:** hold port 0 ready=0 and send 0x11 then 0x22 to sel=0 -> 0x11 held, o_demux_ready=0 for the second word. Raise ready -> 0x22 accepted in that same cycle, and port 0 shows 0x22 with valid continuously 1.
- **Independent ports:** port 0 stalled FULL, then send 0x33 sel=1 -> accepted immediately, lane 1=0x33 next cycle. Port 0 is unchanged.
- **Out-of-range (N=3):** send 300 words with sel=3 -> all accepted, no port valid, o_demux_err high 300 consecutive cycles, o_demux_drop_cnt saturates at 255.
- **Streaming:** ports always ready, random sel over 1000 words -> per-port output order equals input order, no loss, and 1 word/cycle throughput.
